// File: rtl/chu_avalon_audio_stream_pkg.sv
// Shared constants for the Avalon audio data path: register map and
// CTRL/STATUS bit positions.
package chu_audio_stream_pkg;

    localparam int unsigned AVS_AW = 3;
    localparam int unsigned AVS_DW = 32;

    localparam logic [AVS_AW-1:0] ADDR_STATUS   = 3'd0;
    localparam logic [AVS_AW-1:0] ADDR_CTRL     = 3'd1;
    localparam logic [AVS_AW-1:0] ADDR_THRESH   = 3'd2;
    localparam logic [AVS_AW-1:0] ADDR_DAC_DATA = 3'd3;
    localparam logic [AVS_AW-1:0] ADDR_ADC_DATA = 3'd4;
    localparam logic [AVS_AW-1:0] ADDR_ERR_CLR  = 3'd5;

    localparam int unsigned CTRL_W         = 6;
    localparam int unsigned CTRL_DAC_SRC   = 0;
    localparam int unsigned CTRL_ADC_DST   = 1;
    localparam int unsigned CTRL_DAC_WM_IE = 2;
    localparam int unsigned CTRL_ADC_WM_IE = 3;
    localparam int unsigned CTRL_ERR_IE    = 4;
    localparam int unsigned CTRL_ENABLE    = 5;

    localparam int unsigned ST_DAC_FULL    = 0;
    localparam int unsigned ST_DAC_EMPTY   = 1;
    localparam int unsigned ST_ADC_FULL    = 2;
    localparam int unsigned ST_ADC_EMPTY   = 3;
    localparam int unsigned ST_UNDERRUN    = 4;
    localparam int unsigned ST_OVERRUN     = 5;
    localparam int unsigned ST_DAC_LVL_LSB = 8;
    localparam int unsigned ST_ADC_LVL_LSB = 16;

endpackage

// File: rtl/chu_avalon_audio_stream_if.sv
// Avalon-MM slave bus bundle for the audio data path.
interface chu_avalon_audio_stream_if;
    import chu_audio_stream_pkg::*;

    logic [AVS_AW-1:0] avs_address;
    logic              avs_chipselect;
    logic              avs_write;
    logic              avs_read;
    logic [AVS_DW-1:0] avs_writedata;
    logic [AVS_DW-1:0] avs_readdata;

    modport master (
        output avs_address, avs_chipselect, avs_write, avs_read, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_chipselect, avs_write, avs_read, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/chu_avalon_audio_stream_fifo.sv
// Synchronous FIFO with show-ahead head and fill level; push ignored when
// full, pop ignored when empty.
module chu_audio_fifo #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [FIFO_AW:0]  level
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned LVL_W = FIFO_AW + 1;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [LVL_W-1:0]   level_q;
    logic               push_c, pop_c;

    assign full   = (level_q == LVL_W'(DEPTH));
    assign empty  = (level_q == '0);
    assign level  = level_q;
    assign dout   = mem_q[rptr_q];
    assign push_c = wr & ~full;
    assign pop_c  = rd & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_c) wptr_q <= wptr_q + FIFO_AW'(1);
            if (pop_c)  rptr_q <= rptr_q + FIFO_AW'(1);
            if (push_c && !pop_c)      level_q <= level_q + LVL_W'(1);
            else if (pop_c && !push_c) level_q <= level_q - LVL_W'(1);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/chu_avalon_audio_stream.sv
// Avalon-MM audio data path: playback and capture FIFOs between CPU/stream
// side and the codec serialiser, with status, watermarks and error irq.
module chu_avalon_audio_stream
    import chu_audio_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    chu_avalon_audio_stream_if.slave  avs,
    output logic                      irq,
    input  logic                      sample_tick,
    output logic [DATA_W-1:0]         dac_sample,
    input  logic [DATA_W-1:0]         adc_sample,
    input  logic                      strm_dac_wr,
    input  logic [DATA_W-1:0]         strm_dac_data,
    input  logic                      strm_adc_rd,
    output logic [DATA_W-1:0]         strm_adc_data,
    output logic                      strm_dac_full,
    output logic                      strm_adc_empty
);
    localparam int unsigned LVL_W = FIFO_AW + 1;

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [7:0]        dac_low_wm_q, dac_low_wm_d, adc_high_wm_q, adc_high_wm_d;
    logic              underrun_q, underrun_d, overrun_q, overrun_d;
    logic [AVS_DW-1:0] readdata_q, readdata_d;
    logic [DATA_W-1:0] dac_sample_q, dac_sample_d;
    logic              irq_q, irq_d;

    logic              bus_wr_c, bus_rd_c, tick_c;
    logic              dac_push_c, adc_pop_c;
    logic [DATA_W-1:0] dac_din_c, dac_head_c, adc_head_c;
    logic              dac_full_c, dac_empty_c, adc_full_c, adc_empty_c;
    logic [LVL_W-1:0]  dac_level_c, adc_level_c;
    logic [AVS_DW-1:0] status_c;

    assign bus_wr_c = avs.avs_chipselect & avs.avs_write;
    assign bus_rd_c = avs.avs_chipselect & avs.avs_read;
    assign tick_c   = sample_tick & ctrl_q[CTRL_ENABLE];

    // Routing: CTRL selects CPU or stream as DAC producer and ADC consumer.
    assign dac_push_c = ctrl_q[CTRL_DAC_SRC] ? strm_dac_wr
                      : (bus_wr_c && avs.avs_address == ADDR_DAC_DATA);
    assign dac_din_c  = ctrl_q[CTRL_DAC_SRC] ? strm_dac_data : DATA_W'(avs.avs_writedata);
    assign adc_pop_c  = ctrl_q[CTRL_ADC_DST] ? strm_adc_rd
                      : (bus_rd_c && avs.avs_address == ADDR_ADC_DATA);

    chu_audio_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_dac_fifo (
        .clk(clk), .rst_n(reset_n), .wr(dac_push_c), .rd(tick_c), .din(dac_din_c),
        .dout(dac_head_c), .full(dac_full_c), .empty(dac_empty_c), .level(dac_level_c)
    );

    chu_audio_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_adc_fifo (
        .clk(clk), .rst_n(reset_n), .wr(tick_c), .rd(adc_pop_c), .din(adc_sample),
        .dout(adc_head_c), .full(adc_full_c), .empty(adc_empty_c), .level(adc_level_c)
    );

    always_comb begin
        status_c                         = '0;
        status_c[ST_DAC_FULL]            = dac_full_c;
        status_c[ST_DAC_EMPTY]           = dac_empty_c;
        status_c[ST_ADC_FULL]            = adc_full_c;
        status_c[ST_ADC_EMPTY]           = adc_empty_c;
        status_c[ST_UNDERRUN]            = underrun_q;
        status_c[ST_OVERRUN]             = overrun_q;
        status_c[ST_DAC_LVL_LSB +: 8]    = 8'(dac_level_c);
        status_c[ST_ADC_LVL_LSB +: 8]    = 8'(adc_level_c);
    end

    always_comb begin
        ctrl_d        = ctrl_q;
        dac_low_wm_d  = dac_low_wm_q;
        adc_high_wm_d = adc_high_wm_q;
        readdata_d    = '0;
        dac_sample_d  = dac_sample_q;

        if (bus_wr_c) begin
            case (avs.avs_address)
                ADDR_CTRL:   ctrl_d = avs.avs_writedata[CTRL_W-1:0];
                ADDR_THRESH: begin
                    dac_low_wm_d  = avs.avs_writedata[7:0];
                    adc_high_wm_d = avs.avs_writedata[15:8];
                end
                default: ;
            endcase
        end

        if (bus_rd_c) begin
            case (avs.avs_address)
                ADDR_STATUS:   readdata_d = status_c;
                ADDR_CTRL:     readdata_d = AVS_DW'(ctrl_q);
                ADDR_THRESH:   readdata_d = AVS_DW'({adc_high_wm_q, dac_low_wm_q});
                ADDR_ADC_DATA: readdata_d = adc_empty_c ? '0 : AVS_DW'(adc_head_c);
                default:       readdata_d = '0;
            endcase
        end

        // Set events beat a simultaneous W1C clear.
        underrun_d = (underrun_q & ~(bus_wr_c && avs.avs_address == ADDR_ERR_CLR
                                     && avs.avs_writedata[ST_UNDERRUN]))
                   | (tick_c & dac_empty_c);
        overrun_d  = (overrun_q & ~(bus_wr_c && avs.avs_address == ADDR_ERR_CLR
                                    && avs.avs_writedata[ST_OVERRUN]))
                   | (tick_c & adc_full_c);

        if (!ctrl_q[CTRL_ENABLE]) dac_sample_d = '0;
        else if (tick_c)          dac_sample_d = dac_empty_c ? '0 : dac_head_c;

        irq_d = (ctrl_q[CTRL_DAC_WM_IE] && (8'(dac_level_c) <= dac_low_wm_q))
              | (ctrl_q[CTRL_ADC_WM_IE] && (8'(adc_level_c) >= adc_high_wm_q))
              | (ctrl_q[CTRL_ERR_IE] && (underrun_q || overrun_q));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            dac_low_wm_q  <= '0;
            adc_high_wm_q <= '0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
            readdata_q    <= '0;
            dac_sample_q  <= '0;
            irq_q         <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            dac_low_wm_q  <= dac_low_wm_d;
            adc_high_wm_q <= adc_high_wm_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
            readdata_q    <= readdata_d;
            dac_sample_q  <= dac_sample_d;
            irq_q         <= irq_d;
        end
    end

    assign avs.avs_readdata = readdata_q;
    assign dac_sample       = dac_sample_q;
    assign irq              = irq_q;
    assign strm_adc_data    = adc_head_c;
    assign strm_dac_full    = dac_full_c;
    assign strm_adc_empty   = adc_empty_c;

endmodule

// File: tb/tb_chu_avalon_audio_stream.sv
// Directed bench for chu_avalon_audio_stream: vector table for bus/tick
// traffic plus hand sequences for stream routing and mid-run reset.
module tb_chu_avalon_audio_stream;
    import chu_audio_stream_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FIFO_AW = 3;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_TK, OP_IRQ} op_e;

    // OP_WR: write addr/data (tick optional); OP_RD: read, expect exp;
    // OP_TK: tick with adc=data, expect dac_sample; OP_IRQ: wait data cycles, expect irq.
    typedef struct {
        op_e         op;
        logic [2:0]  addr;
        logic [31:0] data;
        bit          tick;
        logic [31:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              irq;
    logic              sample_tick;
    logic [DATA_W-1:0] dac_sample, adc_sample;
    logic              strm_dac_wr, strm_adc_rd;
    logic [DATA_W-1:0] strm_dac_data, strm_adc_data;
    logic              strm_dac_full, strm_adc_empty;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vec[$];

    chu_avalon_audio_stream_if bus ();

    chu_avalon_audio_stream #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .reset_n(reset_n), .avs(bus), .irq(irq),
        .sample_tick(sample_tick), .dac_sample(dac_sample), .adc_sample(adc_sample),
        .strm_dac_wr(strm_dac_wr), .strm_dac_data(strm_dac_data),
        .strm_adc_rd(strm_adc_rd), .strm_adc_data(strm_adc_data),
        .strm_dac_full(strm_dac_full), .strm_adc_empty(strm_adc_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic avs_op(input bit wr, input bit rd, input logic [2:0] a,
                          input logic [31:0] d, input bit tk, input logic [31:0] adc);
        bus.avs_chipselect = wr | rd;
        bus.avs_write      = wr;
        bus.avs_read       = rd;
        bus.avs_address    = a;
        bus.avs_writedata  = d;
        sample_tick        = tk;
        adc_sample         = adc;
        step();
        bus.avs_chipselect = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_read       = 1'b0;
        sample_tick        = 1'b0;
    endtask

    function automatic void v_add(op_e op, logic [2:0] a, logic [31:0] d, bit tk, logic [31:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.tick = tk; v.exp = e;
        vec.push_back(v);
    endfunction
    function automatic void v_wr(logic [2:0] a, logic [31:0] d); v_add(OP_WR, a, d, 1'b0, 0); endfunction
    function automatic void v_rd(logic [2:0] a, logic [31:0] e); v_add(OP_RD, a, 0, 1'b0, e); endfunction
    function automatic void v_tk(logic [31:0] adc, logic [31:0] e); v_add(OP_TK, 0, adc, 1'b1, e); endfunction
    function automatic void v_irq(int w, bit e); v_add(OP_IRQ, 0, w, 1'b0, 32'(e)); endfunction

    task automatic build_vectors();
        // Basic playback and underrun
        v_rd(ADDR_STATUS, 32'h0000_000A);
        v_wr(ADDR_CTRL, 32'h20);
        v_rd(ADDR_CTRL, 32'h20);
        v_wr(ADDR_DAC_DATA, 32'h11); v_wr(ADDR_DAC_DATA, 32'h22); v_wr(ADDR_DAC_DATA, 32'h33);
        v_rd(ADDR_STATUS, 32'h0000_0308);
        v_tk(32'hA1, 32'h11); v_tk(32'hA2, 32'h22); v_tk(32'hA3, 32'h33); v_tk(32'hA4, 32'h0);
        v_rd(ADDR_STATUS, 32'h0004_0012);
        v_wr(ADDR_ERR_CLR, 32'h10);
        v_rd(ADDR_STATUS, 32'h0004_0002);
        v_rd(ADDR_ADC_DATA, 32'hA1); v_rd(ADDR_ADC_DATA, 32'hA2);
        v_rd(ADDR_ADC_DATA, 32'hA3); v_rd(ADDR_ADC_DATA, 32'hA4);
        v_rd(ADDR_ADC_DATA, 32'h0);
        v_rd(ADDR_STATUS, 32'h0000_000A);
        // Fill DAC past depth; ninth write dropped, order preserved over wrap
        for (int i = 1; i <= 9; i++) v_wr(ADDR_DAC_DATA, 32'h100 + 32'(i));
        v_rd(ADDR_STATUS, 32'h0000_0809);
        for (int i = 1; i <= 8; i++) v_tk(32'h200 + 32'(i), 32'h100 + 32'(i));
        v_rd(ADDR_STATUS, 32'h0008_0006);
        // Disabled: tick ignored, no flags, dac_sample forced to 0
        v_wr(ADDR_CTRL, 32'h00);
        v_tk(32'h2FF, 32'h0);
        v_rd(ADDR_STATUS, 32'h0008_0006);
        for (int i = 1; i <= 8; i++) v_rd(ADDR_ADC_DATA, 32'h200 + 32'(i));
        v_rd(ADDR_ADC_DATA, 32'h0);
        v_rd(ADDR_STATUS, 32'h0000_000A);
        // ADC high watermark interrupt
        v_wr(ADDR_THRESH, 32'h0000_0400);
        v_rd(ADDR_THRESH, 32'h0000_0400);
        v_wr(ADDR_CTRL, 32'h28);
        v_irq(1, 1'b0);
        v_tk(32'h1, 32'h0); v_tk(32'h2, 32'h0); v_tk(32'h3, 32'h0);
        v_irq(1, 1'b0);
        v_tk(32'h4, 32'h0);
        v_irq(0, 1'b0);
        v_irq(1, 1'b1);
        v_rd(ADDR_ADC_DATA, 32'h1);
        v_irq(0, 1'b1);
        v_irq(1, 1'b0);
        v_rd(ADDR_ADC_DATA, 32'h2); v_rd(ADDR_ADC_DATA, 32'h3); v_rd(ADDR_ADC_DATA, 32'h4);
        v_rd(ADDR_ADC_DATA, 32'h0);
        v_rd(ADDR_STATUS, 32'h0000_001A);
        v_wr(ADDR_ERR_CLR, 32'h10);
        v_rd(ADDR_STATUS, 32'h0000_000A);
        // Overrun with err_ie, and set-beats-clear on the same edge
        v_wr(ADDR_CTRL, 32'h30);
        for (int i = 1; i <= 9; i++) v_tk(32'h300 + 32'(i), 32'h0);
        v_irq(1, 1'b1);
        v_rd(ADDR_STATUS, 32'h0008_0036);
        v_wr(ADDR_ERR_CLR, 32'h10);
        v_rd(ADDR_STATUS, 32'h0008_0026);
        v_irq(1, 1'b1);
        v_add(OP_WR, ADDR_ERR_CLR, 32'h20, 1'b1, 0);
        v_rd(ADDR_STATUS, 32'h0008_0036);
        v_wr(ADDR_ERR_CLR, 32'h30);
        v_rd(ADDR_STATUS, 32'h0008_0006);
        v_irq(1, 1'b0);
        for (int i = 1; i <= 8; i++) v_rd(ADDR_ADC_DATA, 32'h300 + 32'(i));
        v_rd(ADDR_ADC_DATA, 32'h0);
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] e);
        avs_op(1'b0, 1'b1, a, 0, 1'b0, 0);
        check(name, bus.avs_readdata, e);
    endtask

    initial begin
        reset_n            = 1'b0;
        sample_tick        = 1'b0;
        adc_sample         = '0;
        strm_dac_wr        = 1'b0;
        strm_dac_data      = '0;
        strm_adc_rd        = 1'b0;
        bus.avs_chipselect = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_address    = '0;
        bus.avs_writedata  = '0;
        repeat (2) step();
        reset_n = 1'b1;

        check("reset irq", 32'(irq), 32'h0);
        check("reset dac_sample", dac_sample, 32'h0);
        check("reset readdata", bus.avs_readdata, 32'h0);

        build_vectors();
        foreach (vec[i]) begin
            case (vec[i].op)
                OP_WR: avs_op(1'b1, 1'b0, vec[i].addr, vec[i].data, vec[i].tick, 0);
                OP_RD: begin
                    avs_op(1'b0, 1'b1, vec[i].addr, 0, 1'b0, 0);
                    check($sformatf("vec%0d read a%0d", i, vec[i].addr), bus.avs_readdata, vec[i].exp);
                end
                OP_TK: begin
                    avs_op(1'b0, 1'b0, 0, 0, 1'b1, vec[i].data);
                    check($sformatf("vec%0d dac_sample", i), dac_sample, vec[i].exp);
                end
                default: begin
                    repeat (int'(vec[i].data)) step();
                    check($sformatf("vec%0d irq", i), 32'(irq), vec[i].exp);
                end
            endcase
        end

        // Stream routing
        avs_op(1'b1, 1'b0, ADDR_CTRL, 32'h23, 1'b0, 0);
        strm_dac_wr = 1'b1; strm_dac_data = 32'h501; step();
        strm_dac_data = 32'h502; step();
        strm_dac_wr = 1'b0;
        avs_op(1'b1, 1'b0, ADDR_DAC_DATA, 32'h5FF, 1'b0, 0);
        rd_check("stream status 2 queued", ADDR_STATUS, 32'h0000_0208);
        strm_dac_wr = 1'b1; strm_dac_data = 32'h503;
        sample_tick = 1'b1; adc_sample = 32'h601;
        step();
        strm_dac_wr = 1'b0; sample_tick = 1'b0;
        check("stream push+pop dac_sample", dac_sample, 32'h501);
        rd_check("stream push+pop status", ADDR_STATUS, 32'h0001_0200);
        check("strm_adc_data head", strm_adc_data, 32'h601);
        check("strm_adc_empty low", 32'(strm_adc_empty), 32'h0);
        check("strm_dac_full low", 32'(strm_dac_full), 32'h0);
        rd_check("stream cpu adc peek", ADDR_ADC_DATA, 32'h601);
        rd_check("stream peek no pop", ADDR_STATUS, 32'h0001_0200);
        strm_adc_rd = 1'b1; step(); strm_adc_rd = 1'b0;
        rd_check("stream pop status", ADDR_STATUS, 32'h0000_0208);
        check("strm_adc_empty high", 32'(strm_adc_empty), 32'h1);
        avs_op(1'b0, 1'b0, 0, 0, 1'b1, 32'h602);
        check("stream dac 2nd", dac_sample, 32'h502);
        avs_op(1'b0, 1'b0, 0, 0, 1'b1, 32'h603);
        check("stream dac 3rd (cpu write ignored)", dac_sample, 32'h503);

        // Mid-run reset clears everything
        reset_n = 1'b0; step(); reset_n = 1'b1;
        check("mid reset dac_sample", dac_sample, 32'h0);
        check("mid reset irq", 32'(irq), 32'h0);
        check("mid reset adc empty", 32'(strm_adc_empty), 32'h1);
        rd_check("mid reset status", ADDR_STATUS, 32'h0000_000A);
        rd_check("mid reset ctrl", ADDR_CTRL, 32'h0);
        rd_check("mid reset thresh", ADDR_THRESH, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
